shifter_pipe: RTL

Parametrised, pipelined barrel shifter for the datapath's execute stage. It supports logical left, logical right and arithmetic right shifts, plus an optional rotate-right mode. Each input carries a shift amount and a mode and flows through log2(WIDTH) mux levels, with a configurable register stride between levels. A valid/ready handshake lets the ALU wrapper and writeback apply backpressure, and the result carries carry-out and zero flags.

---
 rtl/shifter_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SLL / SRL / SRA, optional ROR).
//
// Operands pass through log2(WIDTH) mux levels, largest shift first. A
// register stage is placed after every REG_STRIDE levels (and after the last
// level), so latency is L = ceil(SAW / REG_STRIDE). Stall is global: every
// stage holds while the output is valid and not accepted.
//
// Optional feature macro: SHIFTER_PIPE_ROTATE_EN
//   defined   -> Mode 11 rotates right; C is the last bit wrapped to the MSB.
//   undefined -> no wrap-around datapath; Mode 11 behaves exactly as SRL.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous, active-high reset
//   in_valid   operand valid            in_ready   block accepts an operand
//   X          operand                  Sa         shift amount
//   Mode       00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  result valid             out_ready  consumer accepts result
//   Sh         result                   C          last bit shifted out
//   Z          Sh == 0
module shifter_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_STRIDE = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         X,
  input  logic [$clog2(WIDTH)-1:0] Sa,
  input  logic [1:0]               Mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Sh,
  output logic                     C,
  output logic                     Z
);

  localparam int unsigned SAW = $clog2(WIDTH);
  localparam int unsigned L   = (SAW + REG_STRIDE - 1) / REG_STRIDE;

  // Pipeline stage registers; index L-1 is the output register.
  logic [L-1:0][WIDTH-1:0] data_q;
  logic [L-1:0]            carry_q;
  logic [L-1:0]            valid_q;
  logic [L-1:0][SAW-1:0]   sa_q;
  logic [L-1:0][1:0]       mode_q;
  logic                    z_q;

  // Combinational level outputs and the value each stage captures.
  logic [SAW-1:0][WIDTH-1:0] lvl_d;
  logic [SAW-1:0]            lvl_c;
  logic [L-1:0][WIDTH-1:0]   stage_d;
  logic [L-1:0]              stage_c;
  logic                      advance;

  for (genvar j = 0; j < SAW; j++) begin : g_lvl
    localparam int unsigned S = j / REG_STRIDE;  // stage this level belongs to
    localparam int unsigned K = SAW - 1 - j;     // Sa bit handled here
    localparam int unsigned A = 1 << K;          // shift distance

    logic [WIDTH-1:0] d_in;
    logic             c_in;
    logic             en;
    logic [1:0]       md;
    logic [WIDTH-1:0] d_out;
    logic             c_out;

    // Sa and Mode come from the input port in stage 0, else from the
    // register that holds this item's control bits.
    if (S == 0) begin : g_ctl_in
      assign en = Sa[K];
      assign md = Mode;
    end else begin : g_ctl_reg
      assign en = sa_q[S-1][K];
      assign md = mode_q[S-1];
    end

    if (j == 0) begin : g_src_in
      assign d_in = X;
      assign c_in = 1'b0;
    end else if (j % REG_STRIDE == 0) begin : g_src_reg
      assign d_in = data_q[S-1];
      assign c_in = carry_q[S-1];
    end else begin : g_src_chain
      assign d_in = lvl_d[j-1];
      assign c_in = lvl_c[j-1];
    end

    // Carry is the last bit to leave at this level; because levels go
    // largest-first, the last level that shifts leaves the final carry.
    always_comb begin
      d_out = d_in;
      c_out = c_in;
      if (en) begin
        case (md)
          2'b00: begin
            d_out = d_in << A;
            c_out = d_in[WIDTH-A];
          end
          2'b10: begin
            d_out = $signed(d_in) >>> A;
            c_out = d_in[A-1];
          end
`ifdef SHIFTER_PIPE_ROTATE_EN
          2'b11: begin
            d_out = {d_in[A-1:0], d_in[WIDTH-1:A]};
            c_out = d_in[A-1];
          end
`endif
          default: begin
            d_out = d_in >> A;
            c_out = d_in[A-1];
          end
        endcase
      end
    end

    assign lvl_d[j] = d_out;
    assign lvl_c[j] = c_out;
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int unsigned LastLvl =
        ((s + 1) * REG_STRIDE > SAW) ? SAW - 1 : (s + 1) * REG_STRIDE - 1;
    assign stage_d[s] = lvl_d[LastLvl];
    assign stage_c[s] = lvl_c[LastLvl];
  end

  assign advance = out_ready | ~valid_q[L-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q  <= '0;
      carry_q <= '0;
      valid_q <= '0;
      sa_q    <= '0;
      mode_q  <= '0;
      z_q     <= 1'b0;
    end else if (advance) begin
      data_q     <= stage_d;
      carry_q    <= stage_c;
      z_q        <= ~|stage_d[L-1];
      valid_q[0] <= in_valid;
      sa_q[0]    <= Sa;
      mode_q[0]  <= Mode;
      for (int unsigned s = 1; s < L; s++) begin
        valid_q[s] <= valid_q[s-1];
        sa_q[s]    <= sa_q[s-1];
        mode_q[s]  <= mode_q[s-1];
      end
    end
  end

  // Control bits of the last stage and already-consumed Sa bits are dead.
  logic unused_ctl;
  assign unused_ctl = ^{sa_q, mode_q};

  assign in_ready  = advance;
  assign out_valid = valid_q[L-1];
  assign Sh        = data_q[L-1];
  assign C         = carry_q[L-1];
  assign Z         = z_q;

endmodule
